// File: rtl/inta_sequencer_if.sv
// rtl/inta_sequencer_if.sv - CPU-side acknowledge bus between the 8259 core and the INTA sequencer
interface inta_sequencer_if;
  logic       endOfinit;
  logic       int_req;
  logic       inta_n;
  logic       cpu_int;
  logic       imp1;
  logic       imp2;
  logic       endOfimp2;
  logic       data_en;
  logic       ack_abort;
  logic [2:0] seq_state;

  modport slave (
    input  endOfinit, int_req, inta_n,
    output cpu_int, imp1, imp2, endOfimp2, data_en, ack_abort, seq_state
  );

  modport master (
    output endOfinit, int_req, inta_n,
    input  cpu_int, imp1, imp2, endOfimp2, data_en, ack_abort, seq_state
  );
endinterface

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - 8259 interrupt-acknowledge sequencer
// Deglitches INTA and turns the two-pulse acknowledge into imp1/imp2/endOfimp2 strobes.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  inta_sequencer_if.slave      bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ACK1 = 3'd1,
    S_ACK1      = 3'd2,
    S_WAIT_ACK2 = 3'd3,
    S_ACK2      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int              FCW      = (MIN_LOW > 1) ? $clog2(MIN_LOW) : 1;
  localparam logic [FCW-1:0]  FLT_LAST = FCW'(MIN_LOW - 1);
  localparam logic [7:0]      TO_MAX   = 8'(TIMEOUT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FCW-1:0]         r_flt_cnt;
  logic                   r_inta_f;
  logic                   r_fall;
  logic                   r_rise;
  logic                   w_synced;
  logic                   w_differ;
  logic                   w_accept;

  state_t                 r_state;
  state_t                 w_next;
  logic [7:0]             r_to_cnt;
  logic [7:0]             w_to_inc;
  logic [7:0]             w_to_next;
  logic                   w_to_hit;

  logic                   r_cpu_int;
  logic                   r_imp1;
  logic                   r_imp2;
  logic                   r_end_imp2;
  logic                   r_data_en;
  logic                   r_abort;
  logic                   w_cpu_int;
  logic                   w_imp1;
  logic                   w_imp2;
  logic                   w_end_imp2;
  logic                   w_data_en;
  logic                   w_abort;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_synced != r_inta_f);
  assign w_accept = w_differ && (r_flt_cnt == FLT_LAST);

  // Filter only follows the synced level after MIN_LOW consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '1;
      r_flt_cnt <= '0;
      r_inta_f  <= 1'b1;
      r_fall    <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.inta_n};
      r_fall <= w_accept && r_inta_f;
      r_rise <= w_accept && !r_inta_f;
      if (w_accept) begin
        r_inta_f  <= w_synced;
        r_flt_cnt <= '0;
      end else if (w_differ) begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_to_inc = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 8'd1;
  assign w_to_hit = (r_state == S_WAIT_ACK2) && (w_to_inc == TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_to_cnt   <= 8'd0;
      r_cpu_int  <= 1'b0;
      r_imp1     <= 1'b0;
      r_imp2     <= 1'b0;
      r_end_imp2 <= 1'b0;
      r_data_en  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_to_cnt   <= w_to_next;
      r_cpu_int  <= w_cpu_int;
      r_imp1     <= w_imp1;
      r_imp2     <= w_imp2;
      r_end_imp2 <= w_end_imp2;
      r_data_en  <= w_data_en;
      r_abort    <= w_abort;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!bus.endOfinit) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (bus.int_req) w_next = S_WAIT_ACK1;
        S_WAIT_ACK1: begin
          if (r_fall)            w_next = S_ACK1;
          else if (!bus.int_req) w_next = S_IDLE;
        end
        S_ACK1:      if (r_rise) w_next = S_WAIT_ACK2;
        // A second INTA arriving on the timeout clock still completes the cycle.
        S_WAIT_ACK2: begin
          if (r_fall)        w_next = S_ACK2;
          else if (w_to_hit) w_next = S_IDLE;
        end
        S_ACK2:      if (r_rise) w_next = S_DONE;
        S_DONE:      w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_imp1     = (r_state == S_WAIT_ACK1) && (w_next == S_ACK1);
    w_imp2     = (r_state == S_WAIT_ACK2) && (w_next == S_ACK2);
    w_end_imp2 = (r_state == S_ACK2) && (w_next == S_DONE);
    w_abort    = (r_state == S_WAIT_ACK2) && (w_next == S_IDLE) && bus.endOfinit;
    w_cpu_int  = (w_next == S_WAIT_ACK1);
    w_data_en  = (w_next == S_ACK2);
    w_to_next  = ((r_state == S_WAIT_ACK2) && (w_next == S_WAIT_ACK2)) ? w_to_inc : 8'd0;
  end

  assign bus.cpu_int   = r_cpu_int;
  assign bus.imp1      = r_imp1;
  assign bus.imp2      = r_imp2;
  assign bus.endOfimp2 = r_end_imp2;
  assign bus.data_en   = r_data_en;
  assign bus.ack_abort = r_abort;
  assign bus.seq_state = r_state;

endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - directed vector bench for inta_sequencer
module tb_inta_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_eoi;
  logic in_req;
  logic in_inta;

  inta_sequencer_if bus_a ();
  inta_sequencer_if bus_b ();

  assign bus_a.endOfinit = in_eoi;
  assign bus_a.int_req   = in_req;
  assign bus_a.inta_n    = in_inta;
  assign bus_b.endOfinit = in_eoi;
  assign bus_b.int_req   = in_req;
  assign bus_b.inta_n    = in_inta;

  inta_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  inta_sequencer #(.TIMEOUT(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic       inta_n;
    logic       int_req;
    logic       eoi;
    logic [5:0] strb;   // {cpu_int, imp1, imp2, endOfimp2, data_en, ack_abort}
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input int n, input int a, input int r, input int e, input logic [5:0] s, input int st);
    vec_t v;
    v.inta_n  = a[0];
    v.int_req = r[0];
    v.eoi     = e[0];
    v.strb    = s;
    v.st      = st[2:0];
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strb_a();
    return {bus_a.cpu_int, bus_a.imp1, bus_a.imp2, bus_a.endOfimp2, bus_a.data_en, bus_a.ack_abort};
  endfunction

  function automatic logic [5:0] strb_b();
    return {bus_b.cpu_int, bus_b.imp1, bus_b.imp2, bus_b.endOfimp2, bus_b.data_en, bus_b.ack_abort};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic seen_imp2;
    logic [2:0] st_at_abort;
    int at;

    // normal two-pulse cycle, then request re-raise after DONE
    push(2, 1, 1, 1, 6'b100000, 1);
    push(4, 0, 1, 1, 6'b100000, 1);
    push(1, 0, 1, 1, 6'b010000, 2);
    push(1, 0, 1, 1, 6'b000000, 2);
    push(4, 1, 1, 1, 6'b000000, 2);
    push(1, 1, 1, 1, 6'b000000, 3);
    push(4, 0, 1, 1, 6'b000000, 3);
    push(1, 0, 1, 1, 6'b001010, 4);
    push(1, 0, 1, 1, 6'b000010, 4);
    push(4, 1, 1, 1, 6'b000010, 4);
    push(1, 1, 1, 1, 6'b000100, 5);
    push(1, 1, 1, 1, 6'b000000, 0);
    push(1, 1, 1, 1, 6'b100000, 1);
    push(1, 1, 0, 1, 6'b000000, 0);
    // one-clock glitch in WAIT_ACK1
    push(1, 1, 1, 1, 6'b100000, 1);
    push(1, 0, 1, 1, 6'b100000, 1);
    push(5, 1, 1, 1, 6'b100000, 1);
    push(1, 1, 0, 1, 6'b000000, 0);
    // spurious INTA with no request
    push(6, 0, 0, 1, 6'b000000, 0);
    push(6, 1, 0, 1, 6'b000000, 0);
    // endOfinit dropped during ACK2
    push(1, 1, 1, 1, 6'b100000, 1);
    push(4, 0, 1, 1, 6'b100000, 1);
    push(1, 0, 1, 1, 6'b010000, 2);
    push(1, 0, 1, 1, 6'b000000, 2);
    push(4, 1, 1, 1, 6'b000000, 2);
    push(1, 1, 1, 1, 6'b000000, 3);
    push(4, 0, 1, 1, 6'b000000, 3);
    push(1, 0, 1, 1, 6'b001010, 4);
    push(1, 0, 1, 1, 6'b000010, 4);
    push(1, 0, 1, 0, 6'b000000, 0);
    push(5, 1, 1, 0, 6'b000000, 0);
    push(1, 1, 0, 1, 6'b000000, 0);

    rst = 1'b1; in_eoi = 1'b1; in_req = 1'b1; in_inta = 1'b0;
    tick();
    tick();
    chk("reset_strobes_a", 0, {2'b0, strb_a()}, 8'h00);
    chk("reset_state_a",   0, {5'b0, bus_a.seq_state}, 8'h00);
    chk("reset_strobes_b", 0, {2'b0, strb_b()}, 8'h00);
    chk("reset_state_b",   0, {5'b0, bus_b.seq_state}, 8'h00);

    rst = 1'b0;
    foreach (vecs[i]) begin
      in_inta = vecs[i].inta_n;
      in_req  = vecs[i].int_req;
      in_eoi  = vecs[i].eoi;
      tick();
      chk("vec_strobes", i, {2'b0, strb_a()}, {2'b0, vecs[i].strb});
      chk("vec_state",   i, {5'b0, bus_a.seq_state}, {5'b0, vecs[i].st});
    end

    // timeout on the TIMEOUT=10 instance
    in_req = 1'b1; in_eoi = 1'b1; in_inta = 1'b1;
    tick();
    chk("to_wait_ack1", 0, {5'b0, bus_b.seq_state}, 8'd1);
    in_inta = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus_b.imp1) ok = 1'b1;
    end
    chk("to_imp1_seen", 0, {7'b0, ok}, 8'd1);
    in_inta = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus_b.seq_state == 3'd3) ok = 1'b1;
    end
    chk("to_wait_ack2_seen", 0, {7'b0, ok}, 8'd1);
    at = 0; seen_imp2 = 1'b0; st_at_abort = 3'd7;
    for (int i = 1; i <= 30 && at == 0; i++) begin
      tick();
      if (bus_b.imp2) seen_imp2 = 1'b1;
      if (bus_b.ack_abort) begin
        at = i;
        st_at_abort = bus_b.seq_state;
      end
    end
    chk("to_abort_delay", 0, 8'(at), 8'd10);
    chk("to_abort_state", 0, {5'b0, st_at_abort}, 8'd0);
    chk("to_no_imp2",     0, {7'b0, seen_imp2}, 8'd0);
    tick();
    chk("to_abort_width", 0, {7'b0, bus_b.ack_abort}, 8'd0);

    // reset in WAIT_ACK2 at timeout count 5 on the default instance
    rst = 1'b1;
    tick();
    rst = 1'b0; in_req = 1'b1; in_inta = 1'b1;
    tick();
    chk("rst_wait_ack1", 0, {5'b0, bus_a.seq_state}, 8'd1);
    in_inta = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus_a.imp1) ok = 1'b1;
    end
    chk("rst_imp1_seen", 0, {7'b0, ok}, 8'd1);
    in_inta = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus_a.seq_state == 3'd3) ok = 1'b1;
    end
    chk("rst_wait_ack2_seen", 0, {7'b0, ok}, 8'd1);
    repeat (5) tick();
    chk("rst_still_wait_ack2", 0, {5'b0, bus_a.seq_state}, 8'd3);
    rst = 1'b1;
    tick();
    chk("rst_mid_strobes", 0, {2'b0, strb_a()}, 8'h00);
    chk("rst_mid_state",   0, {5'b0, bus_a.seq_state}, 8'd0);
    rst = 1'b0;
    tick();
    chk("rst_cpu_int_back", 0, {7'b0, bus_a.cpu_int}, 8'd1);
    chk("rst_state_back",   0, {5'b0, bus_a.seq_state}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
